// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
// The scanner presents one registered digit plus a one-hot select per scan slot.
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   value,
    output logic                  carry,
    output logic                  borrow,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     sel
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Result is {wrap, next_value}; wrap set only when every digit rolled over.
    function automatic logic [4*DIGITS:0] bcd_up(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [4*DIGITS:0] bcd_down(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    logic [4*DIGITS:0]  up_res;
    logic [4*DIGITS:0]  dn_res;
    logic [IDX_W-1:0]   idx;
    logic [DIV_W-1:0]   div;
    logic [3:0]         cur_nib;
    logic [DIGITS-1:0]  cur_sel;

    assign up_res = bcd_up(value);
    assign dn_res = bcd_down(value);

    // Count stage: clear beats inc/dec, and simultaneous inc+dec holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (clr) begin
                value <= '0;
            end else if (inc && !dec) begin
                value <= up_res[4*DIGITS-1:0];
                carry <= up_res[4*DIGITS];
            end else if (dec && !inc) begin
                value  <= dn_res[4*DIGITS-1:0];
                borrow <= dn_res[4*DIGITS];
            end
        end
    end

    always_comb begin
        cur_nib = 4'd0;
        cur_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = value[4*i +: 4];
                cur_sel[i] = 1'b1;
            end
        end
    end

    // Scan stage: sel and digit both come from pre-edge idx/value, keeping them aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= '0;
            idx   <= '0;
            sel   <= DIGITS'(1);
            digit <= 4'd0;
        end else begin
            sel   <= cur_sel;
            digit <= cur_nib;
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: directed steps plus random traffic, each edge
// compared against an integer-arithmetic reference of count and scan position.
module tb_bcd_scan_counter;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inc, dec, clr;
    logic [15:0]   value;
    logic          carry, borrow;
    logic [3:0]    digit;
    logic [3:0]    sel;

    int checks = 0;
    int errors = 0;

    int        cnt;        // reference count as a plain integer 0..9999
    int        k;          // edges since reset release
    logic [3:0] exp_sel;
    logic [3:0] exp_digit;
    logic       exp_carry, exp_borrow;

    bcd_scan_counter #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr),
        .value(value), .carry(carry), .borrow(borrow),
        .digit(digit), .sel(sel)
    );

    always #5 clk = ~clk;

    function automatic int dec_digit(input int n, input int p);
        int m;
        m = n;
        for (int j = 0; j < p; j++) m = m / 10;
        return m % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        for (int j = 0; j < ND; j++) r[4*j +: 4] = 4'(dec_digit(n, j));
        return r;
    endfunction

    task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        expect_eq({tag, ".value"},  value,         to_bcd(cnt));
        expect_eq({tag, ".carry"},  16'(carry),    16'(exp_carry));
        expect_eq({tag, ".borrow"}, 16'(borrow),   16'(exp_borrow));
        expect_eq({tag, ".sel"},    16'(sel),      16'(exp_sel));
        expect_eq({tag, ".digit"},  16'(digit),    16'(exp_digit));
    endtask

    task automatic model_reset();
        cnt = 0; k = 0;
        exp_sel = 4'b0001; exp_digit = 4'd0;
        exp_carry = 1'b0; exp_borrow = 1'b0;
    endtask

    task automatic step(input logic i, input logic d, input logic c, input string tag);
        int pre_cnt, pos;
        inc = i; dec = d; clr = c;
        pre_cnt = cnt;
        pos = (k / SD) % ND;
        @(posedge clk);
        exp_sel    = 4'(1 << pos);
        exp_digit  = 4'(dec_digit(pre_cnt, pos));
        exp_carry  = 1'b0;
        exp_borrow = 1'b0;
        k++;
        if (c) cnt = 0;
        else if (i && !d) begin
            exp_carry = (cnt == 9999);
            cnt = (cnt + 1) % 10000;
        end else if (d && !i) begin
            exp_borrow = (cnt == 0);
            cnt = (cnt + 9999) % 10000;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic saw_carry;
        int   pos;
        inc = 0; dec = 0; clr = 0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Increment ripple
        saw_carry = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step(1, 0, 0, "inc10");
            saw_carry |= carry;
        end
        expect_eq("ripple10", value, 16'h0010);
        for (int n = 0; n < 90; n++) begin
            step(1, 0, 0, "inc90");
            saw_carry |= carry;
        end
        expect_eq("ripple100", value, 16'h0100);
        expect_eq("no_carry", 16'(saw_carry), 16'd0);

        // Down-wrap then up-wrap
        step(0, 0, 1, "clr0");
        step(0, 1, 0, "downwrap");
        expect_eq("downwrap.value", value, 16'h9999);
        expect_eq("downwrap.borrow", 16'(borrow), 16'd1);
        step(0, 0, 0, "after_dw");
        expect_eq("borrow_pulse", 16'(borrow), 16'd0);
        step(1, 0, 0, "upwrap");
        expect_eq("upwrap.value", value, 16'h0000);
        expect_eq("upwrap.carry", 16'(carry), 16'd1);
        expect_eq("upwrap.borrow", 16'(borrow), 16'd0);
        step(0, 0, 0, "after_uw");
        expect_eq("carry_pulse", 16'(carry), 16'd0);

        // Hold and clear priority
        for (int n = 0; n < 42; n++) step(1, 0, 0, "to42");
        step(1, 1, 0, "incdec_hold");
        expect_eq("hold.value", value, 16'h0042);
        step(1, 0, 1, "clr_inc");
        expect_eq("clr_inc.value", value, 16'h0000);

        // Scan sequence at 4321
        for (int n = 0; n < 4321; n++) step(1, 0, 0, "to4321");
        for (int n = 0; n < 20; n++) begin
            step(0, 0, 0, "scan");
            pos = 0;
            for (int j = 0; j < ND; j++) if (sel[j]) pos = j;
            expect_eq("scan.digit", 16'(digit), 16'(pos + 1));
        end

        // Scan/count interaction
        for (int n = 0; n < 2 * ND * SD; n++) step(1, 0, 0, "scan_inc");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        // Reset mid-scan at 0x0123 with sel=0100
        step(0, 0, 1, "clr_pre");
        for (int n = 0; n < 123; n++) step(1, 0, 0, "to123");
        for (int n = 0; n < 20 && sel !== 4'b0100; n++) step(0, 0, 0, "seek");
        expect_eq("seek.sel", 16'(sel), 16'h0004);
        expect_eq("seek.value", value, 16'h0123);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        rst = 1'b0;
        for (int n = 0; n < 2 * ND * SD; n++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Four-digit decimal up/down counter with a time-multiplexed digit scanner. It is the stage directly upstream of the `bcd` seven-segment converter. Each scan slot presents one 4-bit BCD digit on `digit`, which wires straight into the converter's input, together with a one-hot digit-select for the display's common lines. Counting and scanning are independent; the scanner always shows the current registered count.

## Interface
- `DIGITS`, default 4: number of BCD digits held and scanned (≥1).
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `inc` in 1: count up by one on this edge.
- `dec` in 1: count down by one on this edge.
- `clr` in 1: synchronous clear of the count.
- `value` out 4*DIGITS: full count, digit 0 (units) in bits [3:0].
- `carry` out 1: one-cycle pulse on up-wrap (all 9s → all 0s).
- `borrow` out 1: one-cycle pulse on down-wrap (all 0s → all 9s).
- `digit` out 4: BCD digit for the currently selected position; feeds `bcd`.
- `sel` out DIGITS: one-hot, active-high digit select aligned with `digit`.

## Operation
- Reset (async, immediate) sets all outputs and internal state as follows:
  - `value`=0, `carry`=0, `borrow`=0.
  - scan index=0, divider=0.
  - `sel`=…0001, `digit`=0.
- Count priority, evaluated each rising edge:
  - `clr`: `value` becomes 0, no carry or borrow.
  - else `inc`&`dec` both high: hold.
  - else `inc`: BCD increment.
  - else `dec`: BCD decrement.
  - else: hold.
- BCD increment:
  - Units +1.
  - A digit at 9 becomes 0 and propagates +1 to the next digit.
  - All 9s wraps to all 0s and sets `carry`=1 for exactly that updated cycle.
- BCD decrement:
  - A digit at 0 becomes 9 and propagates −1 to the next digit.
  - All 0s wraps to all 9s and sets `borrow`=1.
- `carry` and `borrow` are registered and cleared on every edge that does not wrap. They are never both high.
- Invariant: every nibble of `value` is 0–9 at all times. Nibbles 10–15 are unreachable.
- Scanner, divider behaviour:
  - The divider counts 0..SCAN_DIV−1 every cycle, unconditionally.
  - On the edge where it is at SCAN_DIV−1, it returns to 0 and the scan index advances (index+1) mod DIGITS.
- Scanner, output registers (each edge):
  - `sel` is loaded with onehot(index).
  - `digit` is loaded with nibble index of `value`.
  - Both are sampled from the pre-edge registers, so the two always stay mutually aligned.
- Scanning is unaffected by `inc`, `dec` and `clr`.

## Timing
- Count latency:
  - `inc`/`dec`/`clr` sampled at edge N.
  - `value` and `carry`/`borrow` reflect it after edge N.
- Display latency:
  - `digit` lags `value` by one cycle.
  - `sel` lags the scan index by one cycle.
- Scan period:
  - Each `sel` pattern holds exactly SCAN_DIV cycles.
  - A full sweep takes DIGITS×SCAN_DIV cycles.
  - SCAN_DIV=1 changes `sel` every cycle.
- Multi-cycle pulses: held `inc` counts once per cycle. There is no edge detection; upstream supplies single-cycle pulses.
- Mid-operation reset:
  - `rst` asserted asynchronously: outputs go to their reset values without waiting for a clock.
  - After release, the first edge resumes normal operation, with the divider starting from 0.
- A `clr` coinciding with a scan advance clears `value`. The scanner advances normally and shows 0 from the following cycle.

## Test plan
- Reset mid-scan:
  - Stimulus: `rst` pulsed between edges while `sel`=0100 and `value`=0x0123.
  - Required: immediately `value`=0, `sel`=0001, `digit`=0, `carry`=0; no clock needed.
- Increment ripple:
  - Stimulus: from 0, 10 single-cycle `inc` pulses.
  - Required: `value`=0x0010.
  - Then 90 more pulses: `value`=0x0100, `carry` never asserted.
- Up-wrap:
  - Stimulus: count to 0x9999, then one `inc`.
  - Required: `value`=0x0000, `carry`=1 for exactly one cycle, `borrow`=0.
- Down-wrap, hold and clear:
  - From 0, one `dec`: `value`=0x9999, `borrow` one-cycle pulse.
  - `inc`&`dec` together: no change, no pulse.
  - `clr`&`inc` together at 0x0042: `value`=0.
- Scan sequence (DIGITS=4, SCAN_DIV=4, `value`=0x4321):
  - Required: `sel` steps 0001,0010,0100,1000,0001, each held exactly 4 cycles.
  - `digit` reads 1,2,3,4 aligned with `sel`.
- Scan/count interaction:
  - Stimulus: `inc` every cycle during a scan sweep.
  - Required: `digit` always equals the selected nibble of `value` from one cycle earlier.
